fifo_rd_streamer: RTL and testbench

Reader-side engine for the project FIFO.
- Drives the FIFO's rd_en and consumes its data_out, empty and underflow signals.
- Drains a software-requested number of words and presents them on a valid/ready stream, with a last marker on the final word.
- Sits between the FIFO read port and any downstream consumer.
- Keeps the FIFO from underflowing while sustaining 1 word/cycle.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 66 ++++++
 rtl/fifo_rd_streamer.sv | 118 +++++++++++
 tb/tb_fifo_rd_streamer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and defaults for the FIFO read streamer.
// Holds the FSM state enum and default data/length widths.
package fifo_rd_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_LEN_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order buffer carrying a last flag per word.
// Ports: push/data_in/last_in write the tail, pop drops the head,
// head_data/head_valid/head_last expose the head, count = occupancy.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int W = DEF_FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         last_in,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic         head_last,
    output logic [1:0]   count
);

    logic [W:0] e0;
    logic [W:0] e1;
    logic [1:0] cnt;
    logic       pop_ok;
    logic       push_ok;

    // A push into a full buffer is only legal when the head leaves.
    assign pop_ok  = pop && (cnt != 2'd0);
    assign push_ok = push && ((cnt != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= {last_in, data_in};
                    else             e1 <= {last_in, data_in};
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= {last_in, data_in};
                    end else begin
                        e0 <= {last_in, data_in};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_data  = e0[W-1:0];
    assign head_last  = e0[W];
    assign head_valid = (cnt != 2'd0);
    assign count      = cnt;

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains xfer_len words from a FIFO onto a valid/ready
// stream with m_last; start/xfer_len in, busy/done/err_underflow out,
// fifo_rd_en/fifo_* to the FIFO read port, m_* to the consumer.
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underflow,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] delivered;
    logic             inflight;
    logic             inflight_last;
    logic [1:0]       buf_count;
    logic [2:0]       occ;
    logic             pop;
    logic             accept;
    logic             last_pop;

    assign pop    = m_valid && m_ready;
    assign accept = (state == IDLE) && start;
    assign len_m1 = len - LEN_W'(1);

    // Buffer slots already claimed after this cycle's pop; the
    // m_ready -> fifo_rd_en path keeps 1 word/cycle with only 2 slots.
    assign occ = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == RUN) && !fifo_empty &&
                        (issued < len) && (occ < 3'd2);

    assign last_pop = pop && m_last && (delivered == len_m1);

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = (xfer_len == '0) ? FIN : RUN;
            end
            RUN: begin
                if (last_pop) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            len           <= '0;
            issued        <= '0;
            delivered     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= fifo_rd_en;
            // Tag the word while it is read so the buffer carries it.
            inflight_last <= fifo_rd_en && (issued == len_m1);
            if (accept) begin
                len           <= xfer_len;
                issued        <= '0;
                delivered     <= '0;
                err_underflow <= 1'b0;
            end else begin
                if (fifo_rd_en) issued <= issued + LEN_W'(1);
                if (pop && (delivered != len))
                    delivered <= delivered + LEN_W'(1);
                if (fifo_underflow && busy) err_underflow <= 1'b1;
            end
        end
    end

    fifo_rd_skid #(
        .W(FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .data_in   (fifo_data_out),
        .last_in   (inflight_last),
        .pop       (pop),
        .head_data (m_data),
        .head_valid(m_valid),
        .head_last (m_last),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed bench for fifo_rd_streamer with a
// behavioural FIFO on the read port and a stream monitor.
module tb_fifo_rd_streamer;

    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] xfer_len;
    logic          busy;
    logic          done;
    logic          err_underflow;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  q[$];

    logic [W-1:0]  got_d[$];
    logic          got_l[$];
    int            got_c[$];
    int            cyc = 0;
    int            rd_cnt = 0;
    int            viol = 0;
    int            done_cnt = 0;
    int            valid_cnt = 0;
    int            stall_bad = 0;
    logic          held = 1'b0;
    logic [W-1:0]  held_d = '0;
    logic          held_l = 1'b0;

    int            total = 0;
    int            bad = 0;
    int            gi = 0;
    int            dsnap = 0;

    always #5 clk = ~clk;

    fifo_rd_streamer #(
        .FIFO_WIDTH(W),
        .LEN_W     (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .xfer_len      (xfer_len),
        .busy          (busy),
        .done          (done),
        .err_underflow (err_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last)
    );

    // Behavioural FIFO: registered read data, registered empty flag.
    always @(posedge clk) begin
        if (fifo_rd_en && (q.size() > 0)) fifo_data_out <= q.pop_front();
        if (wr_en) q.push_back(wr_data);
        fifo_empty <= (q.size() == 0);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_c.push_back(cyc);
        end
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (m_valid) valid_cnt <= valid_cnt + 1;
        if (held && rst_n &&
            (!m_valid || m_data !== held_d || m_last !== held_l))
            stall_bad <= stall_bad + 1;
        held   <= rst_n && m_valid && !m_ready;
        held_d <= m_data;
        held_l <= m_last;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = base + W'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input int n);
        dsnap    = done_cnt;
        start    = 1'b1;
        xfer_len = LW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > dsnap) ok = 1'b1;
        end
    endtask

    task automatic chk_seq(input string tag, input int n,
                           input logic [W-1:0] base);
        chk({tag, "_beats"}, got_d.size() - gi, n);
        for (int i = 0; i < n; i++) begin
            if (gi + i < got_d.size()) begin
                chk({tag, "_data"}, got_d[gi+i], base + W'(i));
                chk({tag, "_last"}, got_l[gi+i], (i == n - 1));
            end
        end
        gi = got_d.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            r0;
        int            v0;
        int            s0;
        int            d0;
        logic [W-1:0]  e0;
        logic [W-1:0]  e1;
        logic [3:0]    pat;

        pat            = 4'b1001;
        rst_n          = 1'b0;
        start          = 1'b0;
        xfer_len       = '0;
        m_ready        = 1'b0;
        wr_en          = 1'b0;
        wr_data        = '0;
        fifo_underflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_err", err_underflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Four preloaded words, consumer always ready.
        load(4, 16'h0001);
        m_ready = 1'b1;
        gi = got_d.size();
        r0 = rd_cnt;
        go(4);
        wait_done(40, ok);
        chk("t1_done_seen", ok, 1);
        if (got_d.size() - gi == 4)
            chk("t1_back_to_back", got_c[gi+3] - got_c[gi], 3);
        chk_seq("t1", 4, 16'h0001);
        chk("t1_rd_pulses", rd_cnt - r0, 4);
        @(negedge clk);
        chk("t1_done_once", done_cnt - dsnap, 1);

        // Partial drain leaves the rest in the FIFO.
        load(8, 16'h0010);
        r0 = rd_cnt;
        go(3);
        wait_done(40, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_busy_after", busy, 0);
        chk_seq("t2", 3, 16'h0010);
        chk("t2_rd_pulses", rd_cnt - r0, 3);
        chk("t2_fifo_left", q.size(), 5);

        // Eight words with a stalling consumer.
        load(3, 16'h0018);
        s0 = stall_bad;
        m_ready = pat[0];
        go(8);
        ok = 1'b0;
        for (int k = 1; k < 200 && !ok; k++) begin
            m_ready = pat[k%4];
            @(negedge clk);
            if (done_cnt > dsnap) ok = 1'b1;
        end
        m_ready = 1'b1;
        chk("t3_done_seen", ok, 1);
        chk_seq("t3", 8, 16'h0013);
        chk("t3_stall_hold", stall_bad - s0, 0);
        chk("t3_rd_while_empty", viol, 0);

        // Start on an empty FIFO, data arrives later.
        r0 = rd_cnt;
        go(2);
        repeat (5) @(negedge clk);
        chk("t4_no_rd_empty", rd_cnt - r0, 0);
        chk("t4_busy_wait", busy, 1);
        load(2, 16'h0021);
        wait_done(40, ok);
        chk("t4_done_seen", ok, 1);
        chk_seq("t4", 2, 16'h0021);
        chk("t4_err", err_underflow, 0);
        chk("t4_rd_while_empty", viol, 0);

        // Zero-length request.
        r0 = rd_cnt;
        v0 = valid_cnt;
        go(0);
        chk("t5_done_pulse", done, 1);
        @(negedge clk);
        chk("t5_done_gone", done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_rd", rd_cnt - r0, 0);
        chk("t5_no_valid", valid_cnt - v0, 0);

        // Reset in the middle of a six-word transfer.
        load(6, 16'h0031);
        gi = got_d.size();
        go(6);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (got_d.size() - gi >= 2) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t6_two_beats", ok, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_data", m_data, 0);
        chk("t6_last", m_last, 0);
        chk("t6_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        load(2, 16'h0041);
        e0 = q[0];
        e1 = q[1];
        gi = got_d.size();
        go(2);
        wait_done(40, ok);
        chk("t6b_done_seen", ok, 1);
        chk("t6b_beats", got_d.size() - gi, 2);
        if (got_d.size() - gi >= 2) begin
            chk("t6b_data0", got_d[gi], e0);
            chk("t6b_last0", got_l[gi], 0);
            chk("t6b_data1", got_d[gi+1], e1);
            chk("t6b_last1", got_l[gi+1], 1);
        end
        gi = got_d.size();

        // Underflow flag while busy is sticky until the next start.
        go(2);
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        chk("t7_err_set", err_underflow, 1);
        load(2, 16'h0051);
        wait_done(40, ok);
        chk("t7_done_seen", ok, 1);
        chk("t7_err_held", err_underflow, 1);
        go(0);
        chk("t7_err_clear", err_underflow, 0);
        @(negedge clk);

        chk("end_rd_while_empty", viol, 0);
        chk("end_stall_hold", stall_bad, 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
